// File: rtl/task_scheduler.sv
// task_scheduler: decodes host instructions and fans them out as parallel SRAM channel commands
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   RPi_inst            - opcode byte followed by NUM_SRAM-1 address fields, MSB-first
//   execute_task        - start request for the presented instruction
//   sram_select         - channel owned by the host (never commanded)
//   inst_valid          - combinational legality of RPi_inst
//   busy                - job in progress
//   job_done/job_reject/job_error - one-cycle status pulses
//   threshold           - background-subtraction threshold register
//   ch_cmd_*            - per-channel command handshake, direction, address, length
//   ch_done             - per-channel completion pulse
// Optional: define TASK_SCHEDULER_TIMEOUT_EN to enable the ISSUE/WAIT watchdog (ABORT + job_error).
module task_scheduler #(
    parameter int NUM_SRAM = 4,
    parameter int ADDR_W = 24,
    parameter logic [ADDR_W-1:0] MAX_ADDRESS = 'h1FFFF,
    parameter int JOB_LEN = 16384,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int INST_W = 8 + ADDR_W*(NUM_SRAM-1),
    localparam int SEL_W = $clog2(NUM_SRAM)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INST_W-1:0]          RPi_inst,
    input  logic                       execute_task,
    input  logic [SEL_W-1:0]           sram_select,
    output logic                       inst_valid,
    output logic                       busy,
    output logic                       job_done,
    output logic                       job_reject,
    output logic                       job_error,
    output logic [7:0]                 threshold,
    output logic [NUM_SRAM-1:0]        ch_cmd_valid,
    input  logic [NUM_SRAM-1:0]        ch_cmd_ready,
    output logic [NUM_SRAM-1:0]        ch_cmd_write,
    output logic [NUM_SRAM*ADDR_W-1:0] ch_cmd_addr,
    output logic [NUM_SRAM*ADDR_W-1:0] ch_cmd_len,
    input  logic [NUM_SRAM-1:0]        ch_done
);
    localparam logic [7:0] OP_THR = 8'hFF;
    localparam logic [7:0] OP_RD  = 8'hFE;
    localparam logic [7:0] OP_WR  = 8'hFD;

    if (NUM_SRAM < 2 || NUM_SRAM > 8 || ADDR_W < 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("task_scheduler: illegal parameter set");
    end

    typedef enum logic [2:0] {IDLE, THRESH, ISSUE, WAIT, DONE, ABORT} state_t;

    state_t                           state_q, state_d;
    logic [7:0]                       opcode;
    logic                             fields_ok;
    logic [NUM_SRAM-1:0]              map_mask;
    logic [NUM_SRAM-1:0][ADDR_W-1:0]  map_addr;
    logic [NUM_SRAM-1:0][ADDR_W-1:0]  addr_q, addr_d;
    logic [NUM_SRAM-1:0]              mapped_q, mapped_d;
    logic [NUM_SRAM-1:0]              valid_q, valid_d;
    logic [NUM_SRAM-1:0]              acc_q, acc_d, acc_n;
    logic [NUM_SRAM-1:0]              flg_q, flg_d, flg_n;
    logic                             wr_q, wr_d;
    logic [7:0]                       thr_val_q, thr_val_d;
    logic [7:0]                       thr_q, thr_d;
    logic                             done_q, done_d;
    logic                             reject_q, reject_d;

    assign opcode = RPi_inst[INST_W-1 -: 8];

    always_comb begin
        fields_ok = 1'b1;
        for (int k = 0; k < NUM_SRAM-1; k++)
            if (RPi_inst[INST_W-9-k*ADDR_W -: ADDR_W] > MAX_ADDRESS) fields_ok = 1'b0;
    end

    assign inst_valid = (opcode == OP_THR || opcode == OP_RD || opcode == OP_WR) && fields_ok;

    // Field k lands on channel (sram_select+1+k) mod NUM_SRAM; the host channel stays unmapped.
    always_comb begin
        map_mask = '0;
        map_addr = '0;
        for (int c = 0; c < NUM_SRAM; c++)
            for (int k = 0; k < NUM_SRAM-1; k++)
                if ((int'(sram_select) + 1 + k) % NUM_SRAM == c) begin
                    map_mask[c] = 1'b1;
                    map_addr[c] = RPi_inst[INST_W-9-k*ADDR_W -: ADDR_W];
                end
    end

`ifdef TASK_SCHEDULER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;
    assign job_error = error_q;
`else
    assign job_error = 1'b0;
`endif

    // A done pulse counts if its channel accepted earlier or in this same cycle.
    assign acc_n = acc_q | (valid_q & ch_cmd_ready);
    assign flg_n = flg_q | (ch_done & acc_n);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mapped_d  = mapped_q;
        valid_d   = valid_q;
        acc_d     = acc_q;
        flg_d     = flg_q;
        wr_d      = wr_q;
        thr_val_d = thr_val_q;
        thr_d     = thr_q;
        done_d    = 1'b0;
        reject_d  = execute_task && (state_q != IDLE || !inst_valid);
        case (state_q)
            IDLE: if (execute_task && inst_valid) begin
                state_d   = (opcode == OP_THR) ? THRESH : ISSUE;
                addr_d    = map_addr;
                mapped_d  = map_mask;
                valid_d   = (opcode == OP_THR) ? '0 : map_mask;
                acc_d     = '0;
                flg_d     = '0;
                wr_d      = opcode == OP_WR;
                thr_val_d = RPi_inst[7:0];
            end
            THRESH: begin
                thr_d   = thr_val_q;
                state_d = DONE;
            end
            ISSUE: begin
                valid_d = valid_q & ~ch_cmd_ready;
                acc_d   = acc_n;
                flg_d   = flg_n;
                if (acc_n == mapped_q) state_d = (flg_n == mapped_q) ? DONE : WAIT;
            end
            WAIT: begin
                flg_d = flg_n;
                if (flg_n == mapped_q) state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ABORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef TASK_SCHEDULER_TIMEOUT_EN
        // Clearing while idle is equivalent to clearing on entry to ISSUE.
        cnt_d = (state_q == IDLE) ? '0 :
                (state_q == ISSUE || state_q == WAIT) ? cnt_q + CNT_W'(1) : cnt_q;
        if ((state_q == ISSUE || state_q == WAIT) && state_d != DONE &&
            cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d = ABORT;
            valid_d = '0;
        end
        error_d = state_q == ABORT;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            mapped_q  <= '0;
            valid_q   <= '0;
            acc_q     <= '0;
            flg_q     <= '0;
            wr_q      <= 1'b0;
            thr_val_q <= 8'h00;
            thr_q     <= 8'h00;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            mapped_q  <= mapped_d;
            valid_q   <= valid_d;
            acc_q     <= acc_d;
            flg_q     <= flg_d;
            wr_q      <= wr_d;
            thr_val_q <= thr_val_d;
            thr_q     <= thr_d;
            done_q    <= done_d;
            reject_q  <= reject_d;
        end
    end

`ifdef TASK_SCHEDULER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end
`endif

    assign busy         = state_q != IDLE;
    assign job_done     = done_q;
    assign job_reject   = reject_q;
    assign threshold    = thr_q;
    assign ch_cmd_valid = valid_q;
    assign ch_cmd_write = {NUM_SRAM{wr_q}};
    assign ch_cmd_addr  = addr_q;
    assign ch_cmd_len   = {NUM_SRAM{ADDR_W'(JOB_LEN)}};

endmodule

// File: tb/tb_task_scheduler.sv
// tb_task_scheduler: scoreboard bench for task_scheduler (4 channels, 24-bit fields)
module tb_task_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] inst;
    logic        execute_task;
    logic [1:0]  sram_select;
    logic        inst_valid, busy, job_done, job_reject, job_error;
    logic [7:0]  threshold;
    logic [3:0]  ch_cmd_valid, ch_cmd_ready, ch_cmd_write, ch_done;
    logic [95:0] ch_cmd_addr, ch_cmd_len;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          ch;
        logic [23:0] addr;
        logic        wr;
    } cmd_t;
    cmd_t sb[$];
    cmd_t mon_e;

    task_scheduler #(.NUM_SRAM(4), .ADDR_W(24), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .RPi_inst(inst), .execute_task(execute_task),
        .sram_select(sram_select), .inst_valid(inst_valid), .busy(busy),
        .job_done(job_done), .job_reject(job_reject), .job_error(job_error),
        .threshold(threshold), .ch_cmd_valid(ch_cmd_valid), .ch_cmd_ready(ch_cmd_ready),
        .ch_cmd_write(ch_cmd_write), .ch_cmd_addr(ch_cmd_addr), .ch_cmd_len(ch_cmd_len),
        .ch_done(ch_done)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] mk(input logic [7:0] op, input logic [23:0] f0, input logic [23:0] f1, input logic [23:0] f2);
        return {op, f0, f1, f2};
    endfunction

    // Scoreboard monitor: every handshake pops the next expected command.
    always @(negedge clk) begin
        #1;
        for (int c = 0; c < 4; c++) begin
            if (ch_cmd_valid[c] && ch_cmd_ready[c]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected ch=%0d addr=%h", c, ch_cmd_addr[c*24 +: 24]);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.ch !== c || ch_cmd_addr[c*24 +: 24] !== mon_e.addr ||
                        ch_cmd_write[c] !== mon_e.wr || ch_cmd_len[c*24 +: 24] !== 24'd16384) begin
                        errors++;
                        $display("FAIL cmd got ch=%0d addr=%h wr=%b len=%0d exp ch=%0d addr=%h wr=%b len=16384",
                                 c, ch_cmd_addr[c*24 +: 24], ch_cmd_write[c], ch_cmd_len[c*24 +: 24],
                                 mon_e.ch, mon_e.addr, mon_e.wr);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task test_reset();
        rst = 1'b1;
        execute_task = 1'b0;
        ch_cmd_ready = 4'h0;
        ch_done = 4'h0;
        inst = '0;
        sram_select = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, job_done, job_reject, job_error, ch_cmd_valid} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {busy, job_done, job_reject, job_error, ch_cmd_valid});
        end
        checks++;
        if (threshold !== 8'h00) begin errors++; $display("FAIL reset_threshold got=%h exp=00", threshold); end
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_opcode00_valid got=%b exp=0", inst_valid); end
        rst = 1'b0;
    endtask

    task test_threshold();
        @(negedge clk);
        sram_select = 2'd0;
        inst = mk(8'hFF, 24'h0, 24'h0, 24'h00002A);
        execute_task = 1'b1;
        #1;
        checks++;
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL thr_inst_valid got=%b exp=1", inst_valid); end
        @(negedge clk);
        execute_task = 1'b0;
        checks++;
        if ({busy, job_done, ch_cmd_valid} !== 6'b100000) begin
            errors++;
            $display("FAIL thr_accept busy,done,valid got=%b exp=100000", {busy, job_done, ch_cmd_valid});
        end
        @(negedge clk);
        checks++;
        if (threshold !== 8'h2A || job_done !== 1'b0) begin
            errors++;
            $display("FAIL thr_value got thr=%h done=%b exp thr=2a done=0", threshold, job_done);
        end
        @(negedge clk);
        checks++;
        if (job_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL thr_done_latency got done=%b busy=%b exp done=1 busy=0", job_done, busy);
        end
        @(negedge clk);
        checks++;
        if (job_done !== 1'b0) begin errors++; $display("FAIL thr_done_pulse got=%b exp=0", job_done); end
        sram_select = 2'd3;
        inst = mk(8'hFF, 24'h123, 24'h456, 24'h000077);
        execute_task = 1'b1;
        @(negedge clk);
        execute_task = 1'b0;
        checks++;
        if (job_reject !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL thr_back_to_back got reject=%b busy=%b exp reject=0 busy=1", job_reject, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (threshold !== 8'h77 || job_done !== 1'b1) begin
            errors++;
            $display("FAIL thr_second got thr=%h done=%b exp thr=77 done=1", threshold, job_done);
        end
    endtask

    task test_read();
        int t;
        @(negedge clk);
        ch_cmd_ready = 4'hF;
        sram_select = 2'd2;
        inst = mk(8'hFE, 24'h100, 24'h200, 24'h300);
        sb.push_back('{0, 24'h200, 1'b0});
        sb.push_back('{1, 24'h300, 1'b0});
        sb.push_back('{3, 24'h100, 1'b0});
        execute_task = 1'b1;
        @(negedge clk);
        execute_task = 1'b0;
        checks++;
        if (ch_cmd_valid !== 4'b1011) begin errors++; $display("FAIL read_valid got=%b exp=1011", ch_cmd_valid); end
        @(negedge clk);
        checks++;
        if (ch_cmd_valid !== 4'b0000 || busy !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL read_accepted got valid=%b busy=%b pending=%0d exp valid=0000 busy=1 pending=0",
                     ch_cmd_valid, busy, sb.size());
        end
        ch_done = 4'b0101;
        @(negedge clk);
        ch_done = 4'b1000;
        @(negedge clk);
        ch_done = 4'b0000;
        checks++;
        if (job_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_partial got done=%b busy=%b exp done=0 busy=1", job_done, busy);
        end
        @(negedge clk);
        ch_done = 4'b0010;
        t = 0;
        for (int i = 1; i <= 6 && t == 0; i++) begin
            @(negedge clk);
            ch_done = 4'b0000;
            if (job_done === 1'b1) t = i;
        end
        checks++;
        if (t != 2) begin errors++; $display("FAIL read_done_latency got=%0d exp=2 cycles", t); end
    endtask

    task test_write();
        int t;
        @(negedge clk);
        ch_cmd_ready = 4'hF;
        sram_select = 2'd0;
        inst = mk(8'hFD, 24'h1FFFF, 24'h0, 24'hABCD);
        sb.push_back('{1, 24'h1FFFF, 1'b1});
        sb.push_back('{2, 24'h0, 1'b1});
        sb.push_back('{3, 24'hABCD, 1'b1});
        execute_task = 1'b1;
        #1;
        checks++;
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL write_max_addr_valid got=%b exp=1", inst_valid); end
        @(negedge clk);
        execute_task = 1'b0;
        checks++;
        if (ch_cmd_valid !== 4'b1110 || ch_cmd_write[3:1] !== 3'b111) begin
            errors++;
            $display("FAIL write_issue got valid=%b write=%b exp valid=1110 write=111x", ch_cmd_valid, ch_cmd_write);
        end
        @(negedge clk);
        ch_done = 4'b1110;
        t = 0;
        for (int i = 1; i <= 6 && t == 0; i++) begin
            @(negedge clk);
            ch_done = 4'b0000;
            if (job_done === 1'b1) t = i;
        end
        checks++;
        if (t != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL write_done got latency=%0d pending=%0d exp latency=2 pending=0", t, sb.size());
        end
    endtask

    task test_reject();
        logic [79:0] tab [5];
        tab[0] = mk(8'hFE, 24'h20000, 24'h0, 24'h0);
        tab[1] = mk(8'hFD, 24'h0, 24'h0, 24'h20000);
        tab[2] = mk(8'h00, 24'h0, 24'h0, 24'h0);
        tab[3] = mk(8'hFC, 24'h1, 24'h2, 24'h3);
        tab[4] = mk(8'hFF, 24'h0, 24'h20000, 24'h2A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            inst = tab[i];
            execute_task = 1'b1;
            #1;
            checks++;
            if (inst_valid !== 1'b0) begin errors++; $display("FAIL reject_valid[%0d] got=%b exp=0", i, inst_valid); end
            @(negedge clk);
            execute_task = 1'b0;
            checks++;
            if (job_reject !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reject_pulse[%0d] got reject=%b busy=%b exp reject=1 busy=0", i, job_reject, busy);
            end
            @(negedge clk);
            checks++;
            if (job_reject !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reject_clear[%0d] got reject=%b busy=%b exp 0 0", i, job_reject, busy);
            end
        end
        checks++;
        if (threshold !== 8'h77) begin errors++; $display("FAIL reject_threshold_kept got=%h exp=77", threshold); end
    endtask

    task test_busy_reject();
        int t;
        @(negedge clk);
        ch_cmd_ready = 4'h0;
        sram_select = 2'd1;
        inst = mk(8'hFE, 24'h11, 24'h22, 24'h33);
        execute_task = 1'b1;
        @(negedge clk);
        inst = mk(8'hFD, 24'h44, 24'h55, 24'h66);
        @(negedge clk);
        execute_task = 1'b0;
        checks++;
        if (job_reject !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_reject got reject=%b busy=%b exp 1 1", job_reject, busy);
        end
        checks++;
        if (ch_cmd_valid !== 4'b1101 || ch_cmd_addr[2*24 +: 24] !== 24'h11 || ch_cmd_write[2] !== 1'b0) begin
            errors++;
            $display("FAIL busy_job_intact got valid=%b addr2=%h wr=%b exp 1101 000011 0",
                     ch_cmd_valid, ch_cmd_addr[2*24 +: 24], ch_cmd_write[2]);
        end
        sb.push_back('{0, 24'h33, 1'b0});
        sb.push_back('{2, 24'h11, 1'b0});
        sb.push_back('{3, 24'h22, 1'b0});
        ch_cmd_ready = 4'hF;
        @(negedge clk);
        ch_done = 4'b1101;
        t = 0;
        for (int i = 1; i <= 6 && t == 0; i++) begin
            @(negedge clk);
            ch_done = 4'b0000;
            if (job_done === 1'b1) t = i;
        end
        checks++;
        if (t == 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL busy_job_done got latency=%0d pending=%0d exp done, pending=0", t, sb.size());
        end
    endtask

    task test_stagger();
        int t;
        @(negedge clk);
        ch_cmd_ready = 4'b1101;
        sram_select = 2'd0;
        inst = mk(8'hFE, 24'hA1, 24'hB2, 24'hC3);
        sb.push_back('{2, 24'hB2, 1'b0});
        sb.push_back('{3, 24'hC3, 1'b0});
        sb.push_back('{1, 24'hA1, 1'b0});
        execute_task = 1'b1;
        @(negedge clk);
        execute_task = 1'b0;
        checks++;
        if (ch_cmd_valid !== 4'b1110) begin errors++; $display("FAIL stag_valid got=%b exp=1110", ch_cmd_valid); end
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            ch_done = (i == 1) ? 4'b0010 : 4'b1100;
            checks++;
            if (ch_cmd_valid !== 4'b0010 || ch_cmd_addr[24 +: 24] !== 24'hA1) begin
                errors++;
                $display("FAIL stag_hold[%0d] got valid=%b addr1=%h exp 0010 0000a1", i, ch_cmd_valid, ch_cmd_addr[24 +: 24]);
            end
        end
        @(negedge clk);
        ch_done = 4'b0000;
        ch_cmd_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ch_cmd_valid !== 4'b0000 || busy !== 1'b1 || job_done !== 1'b0) begin
                errors++;
                $display("FAIL stag_early_done_ignored[%0d] got valid=%b busy=%b done=%b exp 0000 1 0",
                         i, ch_cmd_valid, busy, job_done);
            end
        end
        ch_done = 4'b0010;
        t = 0;
        for (int i = 1; i <= 6 && t == 0; i++) begin
            @(negedge clk);
            ch_done = 4'b0000;
            if (job_done === 1'b1) t = i;
        end
        checks++;
        if (t != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL stag_done got latency=%0d pending=%0d exp latency=2 pending=0", t, sb.size());
        end
    endtask

    task test_reset_mid();
        int bad;
        @(negedge clk);
        ch_cmd_ready = 4'hF;
        sram_select = 2'd3;
        inst = mk(8'hFE, 24'h1, 24'h2, 24'h3);
        sb.push_back('{0, 24'h1, 1'b0});
        sb.push_back('{1, 24'h2, 1'b0});
        sb.push_back('{2, 24'h3, 1'b0});
        execute_task = 1'b1;
        @(negedge clk);
        execute_task = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got=%b exp=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || ch_cmd_valid !== 4'h0 || threshold !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_state got busy=%b valid=%b thr=%h exp 0 0000 00", busy, ch_cmd_valid, threshold);
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            ch_done = (i < 3) ? 4'h7 : 4'h0;
            if (job_done !== 1'b0 || job_error !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rstmid_no_pulses got=%0d bad cycles exp=0", bad); end
    endtask

    task test_timeout();
        int t, dn;
        @(negedge clk);
        ch_cmd_ready = 4'hF;
        sram_select = 2'd0;
        inst = mk(8'hFE, 24'h5, 24'h6, 24'h7);
        sb.push_back('{1, 24'h5, 1'b0});
        sb.push_back('{2, 24'h6, 1'b0});
        sb.push_back('{3, 24'h7, 1'b0});
        execute_task = 1'b1;
        @(negedge clk);
        execute_task = 1'b0;
        t = 0;
        dn = 0;
`ifdef TASK_SCHEDULER_TIMEOUT_EN
        for (int i = 1; i <= 60 && t == 0; i++) begin
            @(negedge clk);
            if (job_done === 1'b1) dn++;
            if (job_error === 1'b1) t = i;
        end
        checks++;
        if (t == 0 || dn != 0) begin
            errors++;
            $display("FAIL timeout_error got error_at=%0d done_count=%0d exp error seen, done_count=0", t, dn);
        end
        checks++;
        if (ch_cmd_valid !== 4'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state got valid=%b busy=%b exp 0000 0", ch_cmd_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (job_error !== 1'b0) begin errors++; $display("FAIL timeout_pulse got=%b exp=0", job_error); end
`else
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (job_done === 1'b1) dn++;
            if (job_error !== 1'b0) t++;
        end
        checks++;
        if (t != 0 || dn != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout got errors=%0d dones=%0d busy=%b exp 0 0 1", t, dn, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || job_error !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout_reset got busy=%b error=%b exp 0 0", busy, job_error);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_read();
        test_write();
        test_reject();
        test_busy_reject();
        test_stagger();
        test_reset_mid();
        test_timeout();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/task_scheduler.md
TASK_SCHEDULER -- requirements
Module: task_scheduler

Interface
REQ-001 Parameter NUM_SRAM, default 4, SHALL set the SRAM channel count; legal range 2-8.
REQ-002 Parameter ADDR_W, default 24, SHALL set the per-field address width.
REQ-003 Parameter MAX_ADDRESS, default 'h1FFFF, SHALL set the highest legal SRAM address.
REQ-004 Parameter JOB_LEN, default 16384, SHALL set the transfer length driven on every command.
REQ-005 Parameter TIMEOUT_CYCLES, default 1000000, SHALL set the job watchdog limit.
REQ-006 Derived constants SHALL be: INST_W = 8 + ADDR_W*(NUM_SRAM-1); SEL_W = $clog2(NUM_SRAM).
REQ-007 clk  in  1  sole clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 RPi_inst  in  INST_W  instruction: [INST_W-1:INST_W-8] opcode, then fields F0..F(NUM_SRAM-2), MSB-first, ADDR_W bits each.
REQ-010 execute_task  in  1  request to start the presented instruction.
REQ-011 sram_select  in  SEL_W  channel currently owned by the host.
REQ-012 inst_valid  out  1  combinational: RPi_inst is legal.
REQ-013 busy  out  1  a job is in progress.
REQ-014 job_done  out  1  one-cycle pulse on successful completion.
REQ-015 job_reject  out  1  one-cycle pulse when execute_task is refused.
REQ-016 job_error  out  1  one-cycle pulse on watchdog abort.
REQ-017 threshold  out  8  background-subtraction threshold register.
REQ-018 ch_cmd_valid / ch_cmd_ready  out / in  NUM_SRAM  per-channel command handshake.
REQ-019 ch_cmd_write  out  NUM_SRAM  per-channel direction: 1 = write, 0 = read.
REQ-020 ch_cmd_addr / ch_cmd_len  out  NUM_SRAM*ADDR_W each  per-channel address and length; channel c occupies slice [c*ADDR_W +: ADDR_W].
REQ-021 ch_done  in  NUM_SRAM  per-channel one-cycle completion pulse.

Function
REQ-022 Opcodes: 0xFF SET_THRESHOLD, 0xFE READ, 0xFD WRITE; all other opcodes, including 0x00, are illegal.
REQ-023 inst_valid SHALL be 1 iff the opcode is legal and every field is <= MAX_ADDRESS.
REQ-024 Field Fk SHALL map to channel (sram_select+1+k) mod NUM_SRAM; the host channel never receives a command.
REQ-025 States: IDLE, THRESH, ISSUE, WAIT, DONE, ABORT.
REQ-026 In IDLE, if execute_task is 1 and inst_valid is 1, the block SHALL latch RPi_inst and the mapping, set busy, and go to THRESH (0xFF) or ISSUE (0xFE/0xFD).
REQ-027 In IDLE, if execute_task is 1 and inst_valid is 0, the block SHALL pulse job_reject and stay in IDLE.
REQ-028 While busy, execute_task SHALL pulse job_reject; the running job is unaffected.
REQ-029 THRESH: threshold <= latched field F(NUM_SRAM-2)[7:0]; then go to DONE.
REQ-030 ISSUE: assert ch_cmd_valid on all mapped channels in the same cycle, with ch_cmd_write = (opcode==0xFD) and ch_cmd_len = JOB_LEN.
REQ-031 ISSUE: each channel's valid SHALL drop in the cycle after it sees valid&ready; address, length and direction SHALL hold stable while valid is high.
REQ-032 ISSUE: when all mapped channels have accepted, go to WAIT.
REQ-033 Done tracking: ch_done SHALL be recorded in sticky per-channel flags only after that channel has accepted; done pulses on unmapped or not-yet-accepted channels are ignored.
REQ-034 WAIT: when every mapped channel is flagged, go to DONE. If all flags complete in the same cycle as the last acceptance, go directly to DONE.
REQ-035 DONE: pulse job_done for one cycle, clear busy, return to IDLE.
REQ-036 Latency: SET_THRESHOLD SHALL show job_done 2 cycles after the accepting edge; a new job SHALL be acceptable in the cycle after job_done.

Reset
REQ-037 With rst high at a clock edge: state SHALL be IDLE; busy, job_done, job_reject, job_error, all ch_cmd_valid, all done flags and the watchdog counter SHALL be 0; threshold SHALL be 0x00.
REQ-038 Reset mid-job SHALL abort the job with no job_done or job_error pulse.

Configuration
REQ-039 With TASK_SCHEDULER_TIMEOUT_EN defined, a counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE and WAIT.
REQ-040 With TASK_SCHEDULER_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL move the block to ABORT; ABORT drops all ch_cmd_valid, pulses job_error, clears busy and returns to IDLE.
REQ-041 Without TASK_SCHEDULER_TIMEOUT_EN, no counter SHALL exist and job_error SHALL be tied to 0.

Verification
REQ-042 sram_select=0, inst {FF,0,0,0x00002A}, execute_task 1 cycle -> threshold=0x2A, job_done 2 cycles later.
REQ-043 sram_select=2, READ with F0=0x100, F1=0x200, F2=0x300 -> ch3=0x100, ch0=0x200, ch1=0x300, ch2 valid=0; job_done after last ch_done.
REQ-044 Field=0x20000 or opcode 0x00 -> inst_valid=0, job_reject pulse, busy stays 0.
REQ-045 Staggered ready (ch1 3 cycles late) plus ch_done on ch1 before acceptance -> that early done is ignored; completion waits for a post-accept ch_done.
REQ-046 TASK_SCHEDULER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, ch_done withheld -> job_error pulse, all valids 0, busy 0; rst mid-WAIT -> no pulses.
